// File: rtl/serial_comparator.sv
// serial_comparator
// Compares two WIDTH-bit operands that arrive one bit pair per valid cycle and
// reports the ordering of A against B once all WIDTH pairs have been consumed.
//
// Parameters
//   WIDTH     : operand length in bits (2..32)
//   MSB_FIRST : 1 = bits arrive MSB first, 0 = LSB first
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a new comparison (accepted in IDLE and DONE)
//   bit_valid in   A/B carry a valid bit pair this cycle (used in RUN only)
//   A, B      in   serial operand bits
//   busy      out  high while a comparison is in progress
//   done      out  one-cycle pulse when a new result is valid
//   GT/ET/LT  out  last completed result (one-hot), A>B / A==B / A<B

module serial_comparator #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic A,
    input  logic B,
    output logic busy,
    output logic done,
    output logic GT,
    output logic ET,
    output logic LT
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] REL_EQ = 2'd0;
    localparam logic [1:0] REL_GT = 2'd1;
    localparam logic [1:0] REL_LT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_comparator: WIDTH must be in 2..32");
    end

    logic [1:0]       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt,   w_cnt_d;
    logic [1:0]       r_rel,   w_rel_d;
    logic             r_busy,  w_busy_d;
    logic             r_done,  w_done_d;
    logic             r_gt,    w_gt_d;
    logic             r_et,    w_et_d;
    logic             r_lt,    w_lt_d;

    logic [1:0]       w_rel_pair;
    logic             w_load;

    // Relation after folding in the current pair. MSB first: the first
    // difference decides and locks. LSB first: the latest difference wins.
    always_comb begin
        w_rel_pair = r_rel;
        if (A != B) begin
            if (!MSB_FIRST || (r_rel == REL_EQ)) begin
                w_rel_pair = A ? REL_GT : REL_LT;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rel_d   = r_rel;
        w_load    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_RUN;
                    w_cnt_d   = '0;
                    w_rel_d   = REL_EQ;
                end
            end
            ST_RUN: begin
                // start is deliberately ignored here
                if (bit_valid) begin
                    w_rel_d = w_rel_pair;
                    w_cnt_d = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_d = ST_DONE;
                        w_load    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_d = ST_RUN;
                    w_cnt_d   = '0;
                    w_rel_d   = REL_EQ;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
                w_rel_d   = REL_EQ;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_comb begin
        w_busy_d = (w_state_d == ST_RUN);
        w_done_d = (w_state_d == ST_DONE);
        w_gt_d   = r_gt;
        w_et_d   = r_et;
        w_lt_d   = r_lt;
        if (w_load) begin
            w_gt_d = (w_rel_pair == REL_GT);
            w_et_d = (w_rel_pair == REL_EQ);
            w_lt_d = (w_rel_pair == REL_LT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rel   <= REL_EQ;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_et    <= 1'b1;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rel   <= w_rel_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_gt    <= w_gt_d;
            r_et    <= w_et_d;
            r_lt    <= w_lt_d;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign GT   = r_gt;
    assign ET   = r_et;
    assign LT   = r_lt;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: an MSB-first and an LSB-first
// instance share the same input stream; each scenario checks the instance
// it targets against hand-computed results.

module tb_serial_comparator;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic bit_valid;
    logic A;
    logic B;

    logic busy_m, done_m, gt_m, et_m, lt_m;
    logic busy_l, done_l, gt_l, et_l, lt_l;

    int n_vec = 0;
    int n_bad = 0;

    int done_cnt = 0;
    int busy_cnt = 0;

    logic [2:0] res_m;
    logic [2:0] res_l;
    assign res_m = {gt_m, et_m, lt_m};
    assign res_l = {gt_l, et_l, lt_l};

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_ET = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    always #5 clk = ~clk;

    serial_comparator #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .A         (A),
        .B         (B),
        .busy      (busy_m),
        .done      (done_m),
        .GT        (gt_m),
        .ET        (et_m),
        .LT        (lt_m)
    );

    serial_comparator #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) dut_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .A         (A),
        .B         (B),
        .busy      (busy_l),
        .done      (done_l),
        .GT        (gt_l),
        .ET        (et_l),
        .LT        (lt_l)
    );

    // Counts done pulses and busy cycles of the MSB-first instance.
    always @(negedge clk) begin
        if (done_m) done_cnt++;
        if (busy_m) busy_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // start for one cycle, then 8 pairs with an optional gap before pair
    // index gap_at. Returns with the last pair just consumed.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit lsb,
                        input int gap_at, input int gap_len, output int cycles);
        cycles    = 0;
        start     = 1'b1;
        bit_valid = 1'b0;
        tick();
        cycles++;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bit_valid = 1'b0;
                    tick();
                    cycles++;
                end
            end
            A         = lsb ? a[i] : a[7-i];
            B         = lsb ? b[i] : b[7-i];
            bit_valid = 1'b1;
            tick();
            cycles++;
        end
        bit_valid = 1'b0;
        A         = 1'b0;
        B         = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        A         = 1'b0;
        B         = 1'b0;
        tick();
        tick();
        n_vec++; if (busy_m !== 1'b0) begin n_bad++;
            $display("FAIL reset_busy got %b want 0", busy_m); end
        n_vec++; if (done_m !== 1'b0) begin n_bad++;
            $display("FAIL reset_done got %b want 0", done_m); end
        n_vec++; if (res_m !== R_ET) begin n_bad++;
            $display("FAIL reset_res_m got %b want %b", res_m, R_ET); end
        n_vec++; if (res_l !== R_ET) begin n_bad++;
            $display("FAIL reset_res_l got %b want %b", res_l, R_ET); end
        rst_n = 1'b1;
    endtask

    task automatic test_gt;
        int cyc;
        int d0;
        send(8'hA5, 8'hA3, 1'b0, -1, 0, cyc);
        d0 = done_cnt;
        n_vec++; if (done_m !== 1'b1) begin n_bad++;
            $display("FAIL gt_done got %b want 1", done_m); end
        n_vec++; if (res_m !== R_GT) begin n_bad++;
            $display("FAIL gt_res got %b want %b", res_m, R_GT); end
        n_vec++; if (busy_m !== 1'b0) begin n_bad++;
            $display("FAIL gt_busy_in_done got %b want 0", busy_m); end
        tick();
        n_vec++; if (done_m !== 1'b0) begin n_bad++;
            $display("FAIL gt_done_width got %b want 0", done_m); end
        n_vec++; if (done_cnt - d0 !== 1) begin n_bad++;
            $display("FAIL gt_done_pulses got %0d want 1", done_cnt - d0); end
        n_vec++; if (res_m !== R_GT) begin n_bad++;
            $display("FAIL gt_hold_idle got %b want %b", res_m, R_GT); end
    endtask

    task automatic test_equal;
        int cyc;
        busy_cnt = 0;
        send(8'h3C, 8'h3C, 1'b0, -1, 0, cyc);
        n_vec++; if (done_m !== 1'b1) begin n_bad++;
            $display("FAIL eq_done got %b want 1", done_m); end
        n_vec++; if (res_m !== R_ET) begin n_bad++;
            $display("FAIL eq_res got %b want %b", res_m, R_ET); end
        tick();
        n_vec++; if (busy_cnt !== 8) begin n_bad++;
            $display("FAIL eq_busy_cycles got %0d want 8", busy_cnt); end
    endtask

    task automatic test_lsb_first;
        int cyc;
        send(8'h01, 8'h80, 1'b1, -1, 0, cyc);
        n_vec++; if (done_l !== 1'b1) begin n_bad++;
            $display("FAIL lsb_done got %b want 1", done_l); end
        n_vec++; if (res_l !== R_LT) begin n_bad++;
            $display("FAIL lsb_lt got %b want %b", res_l, R_LT); end
        tick();
        send(8'h0E, 8'h0B, 1'b1, -1, 0, cyc);
        n_vec++; if (res_l !== R_GT) begin n_bad++;
            $display("FAIL lsb_gt got %b want %b", res_l, R_GT); end
        tick();
    endtask

    task automatic test_gap;
        int cyc;
        send(8'hF0, 8'h0F, 1'b0, 3, 3, cyc);
        n_vec++; if (cyc !== 12) begin n_bad++;
            $display("FAIL gap_latency got %0d want 12", cyc); end
        n_vec++; if (done_m !== 1'b1) begin n_bad++;
            $display("FAIL gap_done got %b want 1", done_m); end
        n_vec++; if (res_m !== R_GT) begin n_bad++;
            $display("FAIL gap_res got %b want %b", res_m, R_GT); end
        tick();
    endtask

    task automatic test_reset_mid;
        logic [7:0] a = 8'h55;
        logic [7:0] b = 8'hAA;
        int cyc;
        int d0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A = a[7-i];
            B = b[7-i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        n_vec++; if (busy_m !== 1'b1) begin n_bad++;
            $display("FAIL mid_busy got %b want 1", busy_m); end
        n_vec++; if (res_m !== R_GT) begin n_bad++;
            $display("FAIL mid_hold_run got %b want %b", res_m, R_GT); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (busy_m !== 1'b0) begin n_bad++;
            $display("FAIL mid_async_busy got %b want 0", busy_m); end
        n_vec++; if (res_m !== R_ET) begin n_bad++;
            $display("FAIL mid_async_res got %b want %b", res_m, R_ET); end
        d0 = done_cnt;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_vec++; if (done_cnt - d0 !== 0) begin n_bad++;
            $display("FAIL mid_no_done got %0d want 0", done_cnt - d0); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        // start offered immediately after reset release
        send(8'h10, 8'h20, 1'b0, -1, 0, cyc);
        n_vec++; if (done_m !== 1'b1) begin n_bad++;
            $display("FAIL post_rst_done got %b want 1", done_m); end
        n_vec++; if (res_m !== R_LT) begin n_bad++;
            $display("FAIL post_rst_res got %b want %b", res_m, R_LT); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [7:0] a = 8'h0F;
        logic [7:0] b = 8'h0E;
        logic [7:0] c = 8'h00;
        logic [7:0] d = 8'h01;
        start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            A = a[7-i];
            B = b[7-i];
            bit_valid = 1'b1;
            tick();
            if (i == 3) begin
                n_vec++; if (busy_m !== 1'b1 || done_m !== 1'b0) begin n_bad++;
                    $display("FAIL b2b_run_start got busy=%b done=%b want 1/0",
                             busy_m, done_m); end
            end
        end
        n_vec++; if (done_m !== 1'b1) begin n_bad++;
            $display("FAIL b2b_first_done got %b want 1", done_m); end
        n_vec++; if (res_m !== R_GT) begin n_bad++;
            $display("FAIL b2b_first_res got %b want %b", res_m, R_GT); end
        // start still high in the DONE cycle
        bit_valid = 1'b0;
        tick();
        start = 1'b0;
        n_vec++; if (busy_m !== 1'b1 || done_m !== 1'b0) begin n_bad++;
            $display("FAIL b2b_restart got busy=%b done=%b want 1/0", busy_m, done_m); end
        for (int i = 0; i < 8; i++) begin
            A = c[7-i];
            B = d[7-i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        n_vec++; if (done_m !== 1'b1) begin n_bad++;
            $display("FAIL b2b_second_done got %b want 1", done_m); end
        n_vec++; if (res_m !== R_LT) begin n_bad++;
            $display("FAIL b2b_second_res got %b want %b", res_m, R_LT); end
        tick();
    endtask

    task automatic test_start_bit_ignored;
        // pair offered with start is not consumed: 1 extra pair A>B is dropped
        start     = 1'b1;
        bit_valid = 1'b1;
        A         = 1'b1;
        B         = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            A = 1'b0;
            B = 1'b0;
            tick();
        end
        n_vec++; if (done_m !== 1'b0 || busy_m !== 1'b1) begin n_bad++;
            $display("FAIL ign_early got done=%b busy=%b want 0/1", done_m, busy_m); end
        tick();
        bit_valid = 1'b0;
        n_vec++; if (done_m !== 1'b1) begin n_bad++;
            $display("FAIL ign_done got %b want 1", done_m); end
        n_vec++; if (res_m !== R_ET) begin n_bad++;
            $display("FAIL ign_res got %b want %b", res_m, R_ET); end
        tick();
    endtask

    initial begin
        test_reset();
        test_gt();
        test_equal();
        test_lsb_first();
        test_gap();
        test_reset_mid();
        test_gap();
        test_back_to_back();
        test_start_bit_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
